// File: rtl/aurora_frame_rx_pkg.sv
// Shared definitions for the Aurora user-stream framer/deframer pair:
// header field layout, receive FSM state encoding and checksum fold.
package aurora_frame_rx_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
    localparam int          HDR_SYNC_LSB      = 16;
    localparam int          HDR_LEN_LSB       = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DISCARD = 2'd3
    } rx_state_e;

    // Sync pattern field of a header word.
    function automatic logic [15:0] hdr_sync(input logic [31:0] w);
        return w[HDR_SYNC_LSB +: 16];
    endfunction

    // Payload length field of a header word.
    function automatic logic [15:0] hdr_len(input logic [31:0] w);
        return w[HDR_LEN_LSB +: 16];
    endfunction

    // Frame checksum is the running XOR of all payload words.
    function automatic logic [31:0] chk_fold(input logic [31:0] acc, input logic [31:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/aurora_frame_rx_fifo.sv
// Payload buffer with speculative write pointer: words are written at
// wr_spec, become visible to the reader only on commit, and are thrown
// away on rollback. Read side is a RAM read stage plus an output register,
// giving first-word-fall-through with one word per cycle.
module aurora_frame_rx_fifo #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [32:0]   wr_data,
    input  logic          commit,
    input  logic          rollback,
    output logic [AW:0]   free_space,
    output logic [AW:0]   level,
    output logic [31:0]   m_data,
    output logic          m_last,
    output logic          m_valid,
    input  logic          m_ready
);

    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_PTR = {1'b1, {AW{1'b0}}};

    logic [32:0] mem_r [DEPTH];
    logic [32:0] ram_q_r;
    logic [32:0] out_r;
    logic        mid_valid_r;
    logic        out_valid_r;
    logic [AW:0] wr_spec_r;
    logic [AW:0] wr_commit_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] ram_rd_ptr_r;
    logic [AW:0] level_r;

    logic        pop_s;
    logic        load_out_s;
    logic        rd_en_s;
    logic        full_s;
    logic        wr_ok_s;
    logic [AW:0] wr_spec_next_s;
    logic [AW:0] wr_commit_next_s;
    logic [AW:0] rd_ptr_next_s;

    // Read pipeline handshakes and next pointer values.
    always_comb begin
        pop_s      = out_valid_r && m_ready;
        load_out_s = mid_valid_r && (!out_valid_r || pop_s);
        rd_en_s    = (ram_rd_ptr_r != wr_commit_r) && (!mid_valid_r || load_out_s);
        full_s     = (wr_spec_r[AW] != rd_ptr_r[AW]) && (wr_spec_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        wr_ok_s    = wr_en && !full_s;
        if (rollback) begin
            wr_spec_next_s = wr_commit_r;
        end else if (wr_ok_s) begin
            wr_spec_next_s = wr_spec_r + PTR_ONE;
        end else begin
            wr_spec_next_s = wr_spec_r;
        end
        if (commit) begin
            wr_commit_next_s = wr_spec_r;
        end else begin
            wr_commit_next_s = wr_commit_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Payload RAM write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_spec_r[AW-1:0]] <= wr_data;
        end
        if (rd_en_s) begin
            ram_q_r <= mem_r[ram_rd_ptr_r[AW-1:0]];
        end
    end

    // Pointers, pipeline valids, output register and level.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_spec_r    <= '0;
            wr_commit_r  <= '0;
            rd_ptr_r     <= '0;
            ram_rd_ptr_r <= '0;
            mid_valid_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_r        <= 33'd0;
            level_r      <= '0;
        end else begin
            wr_spec_r   <= wr_spec_next_s;
            wr_commit_r <= wr_commit_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= wr_commit_next_s - rd_ptr_next_s;
            if (rd_en_s) begin
                ram_rd_ptr_r <= ram_rd_ptr_r + PTR_ONE;
                mid_valid_r  <= 1'b1;
            end else if (load_out_s) begin
                mid_valid_r  <= 1'b0;
            end
            if (load_out_s) begin
                out_r       <= ram_q_r;
                out_valid_r <= 1'b1;
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Space is counted against the released read pointer, so the word held
    // in the output register still occupies its slot.
    assign free_space = DEPTH_PTR - (wr_spec_r - rd_ptr_r);
    assign level      = level_r;
    assign m_data     = out_r[31:0];
    assign m_last     = out_r[32];
    assign m_valid    = out_valid_r;

endmodule

// File: rtl/aurora_frame_rx.sv
// Aurora user RX deframer: validates header, length and XOR checksum,
// buffers payload speculatively and releases only good frames on an
// AXI-Stream master. Status counters saturate.
module aurora_frame_rx
    import aurora_frame_rx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 1024,
    parameter int          MAX_LEN    = 256,
    parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
    parameter int          CNT_W      = 16
) (
    input  logic                          user_clk,
    input  logic                          reset,
    input  logic                          channel_up,
    input  logic [31:0]                   rx_tdata,
    input  logic [3:0]                    rx_tkeep,
    input  logic                          rx_tlast,
    input  logic                          rx_tvalid,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [CNT_W-1:0]              frame_ok_cnt,
    output logic [CNT_W-1:0]              chk_err_cnt,
    output logic [CNT_W-1:0]              fmt_err_cnt,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rx_state_e         state_r;
    rx_state_e         state_next_s;
    logic [31:0]       acc_r;
    logic [15:0]       remain_r;
    logic [CNT_W-1:0]  ok_cnt_r;
    logic [CNT_W-1:0]  chk_cnt_r;
    logic [CNT_W-1:0]  fmt_cnt_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic [AW:0]       free_s;
    logic [15:0]       len_s;
    logic              keep_ok_s;
    logic              hdr_ok_s;
    logic              wr_en_s;
    logic              wr_last_s;
    logic              commit_s;
    logic              rollback_s;
    logic              load_len_s;
    logic              pay_s;
    logic              inc_ok_s;
    logic              inc_chk_s;
    logic              inc_fmt_s;
    logic              inc_drop_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Frame FSM state register.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and per-beat control strobes.
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        wr_last_s    = 1'b0;
        commit_s     = 1'b0;
        rollback_s   = 1'b0;
        load_len_s   = 1'b0;
        pay_s        = 1'b0;
        inc_ok_s     = 1'b0;
        inc_chk_s    = 1'b0;
        inc_fmt_s    = 1'b0;
        inc_drop_s   = 1'b0;
        len_s        = hdr_len(rx_tdata);
        keep_ok_s    = (rx_tkeep == 4'hF);
        hdr_ok_s     = keep_ok_s && (hdr_sync(rx_tdata) == SYNC_WORD) && (len_s >= 16'd1)
                       && (32'(len_s) <= 32'(MAX_LEN)) && !rx_tlast;
        if (!channel_up) begin
            // Link loss abandons any frame in flight.
            rollback_s   = 1'b1;
            state_next_s = ST_IDLE;
            if ((state_r == ST_PAYLOAD) || (state_r == ST_CHECK)) begin
                inc_fmt_s = 1'b1;
            end else begin
                inc_fmt_s = 1'b0;
            end
        end else if (rx_tvalid) begin
            case (state_r)
                ST_IDLE: begin
                    if (hdr_ok_s) begin
                        if (32'(len_s) <= 32'(free_s)) begin
                            load_len_s   = 1'b1;
                            state_next_s = ST_PAYLOAD;
                        end else begin
                            inc_drop_s   = 1'b1;
                            state_next_s = ST_DISCARD;
                        end
                    end else begin
                        inc_fmt_s    = 1'b1;
                        state_next_s = rx_tlast ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!keep_ok_s || rx_tlast) begin
                        inc_fmt_s    = 1'b1;
                        rollback_s   = 1'b1;
                        state_next_s = rx_tlast ? ST_IDLE : ST_DISCARD;
                    end else begin
                        wr_en_s   = 1'b1;
                        pay_s     = 1'b1;
                        wr_last_s = (remain_r == 16'd1);
                        if (remain_r == 16'd1) begin
                            state_next_s = ST_CHECK;
                        end else begin
                            state_next_s = ST_PAYLOAD;
                        end
                    end
                end
                ST_CHECK: begin
                    if (!keep_ok_s || !rx_tlast) begin
                        inc_fmt_s    = 1'b1;
                        rollback_s   = 1'b1;
                        state_next_s = rx_tlast ? ST_IDLE : ST_DISCARD;
                    end else if (rx_tdata == acc_r) begin
                        commit_s     = 1'b1;
                        inc_ok_s     = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        inc_chk_s    = 1'b1;
                        rollback_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (rx_tlast) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DISCARD;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Checksum accumulator and remaining-length counter.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            acc_r    <= 32'd0;
            remain_r <= 16'd0;
        end else if (load_len_s) begin
            acc_r    <= 32'd0;
            remain_r <= len_s;
        end else if (pay_s) begin
            acc_r    <= chk_fold(acc_r, rx_tdata);
            remain_r <= remain_r - 16'd1;
        end
    end

    // Saturating status counters.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            ok_cnt_r   <= '0;
            chk_cnt_r  <= '0;
            fmt_cnt_r  <= '0;
            drop_cnt_r <= '0;
        end else begin
            if (inc_ok_s)   ok_cnt_r   <= sat_inc(ok_cnt_r);
            if (inc_chk_s)  chk_cnt_r  <= sat_inc(chk_cnt_r);
            if (inc_fmt_s)  fmt_cnt_r  <= sat_inc(fmt_cnt_r);
            if (inc_drop_s) drop_cnt_r <= sat_inc(drop_cnt_r);
        end
    end

    aurora_frame_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (user_clk),
        .reset      (reset),
        .wr_en      (wr_en_s),
        .wr_data    ({wr_last_s, rx_tdata}),
        .commit     (commit_s),
        .rollback   (rollback_s),
        .free_space (free_s),
        .level      (fifo_level),
        .m_data     (m_axis_tdata),
        .m_last     (m_axis_tlast),
        .m_valid    (m_axis_tvalid),
        .m_ready    (m_axis_tready)
    );

    assign frame_ok_cnt = ok_cnt_r;
    assign chk_err_cnt  = chk_cnt_r;
    assign fmt_err_cnt  = fmt_cnt_r;
    assign drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_aurora_frame_rx.sv
// Self-checking bench for aurora_frame_rx: table of frame vectors,
// directed latency/drop/link-loss/reset sequences, then random frames
// with random output throttling against a frame-level scoreboard.
module tb_aurora_frame_rx;

    localparam int DEPTH   = 64;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic              user_clk = 1'b0;
    logic              reset = 1'b1;
    logic              channel_up = 1'b1;
    logic [31:0]       rx_tdata = 32'd0;
    logic [3:0]        rx_tkeep = 4'hF;
    logic              rx_tlast = 1'b0;
    logic              rx_tvalid = 1'b0;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [CNT_W-1:0]  frame_ok_cnt, chk_err_cnt, fmt_err_cnt, drop_cnt;
    logic [LW-1:0]     fifo_level;

    aurora_frame_rx #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .SYNC_WORD(16'hA55A), .CNT_W(CNT_W)) dut (
        .user_clk(user_clk), .reset(reset), .channel_up(channel_up),
        .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast), .rx_tvalid(rx_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .frame_ok_cnt(frame_ok_cnt), .chk_err_cnt(chk_err_cnt), .fmt_err_cnt(fmt_err_cnt),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ok = 0, m_chk = 0, m_fmt = 0, m_drop = 0;
    int exp_total = 0;
    int obs_total = 0;
    int hold_err  = 0;
    int ready_mode = 0;
    bit gap_en = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = 33'd0;

    typedef struct {
        logic [15:0] sync;
        logic [15:0] len;
        logic [3:0]  hkeep;
        logic        hlast;
        int          kind;   // 0 normal, 1 early tlast, 2 junk to tlast, 3 header only, 4 checksum w/o tlast
        int          npay;
        logic [31:0] base;
        logic [31:0] chk_xor;
        int          e_ok, e_chk, e_fmt;
    } vec_t;

    vec_t vecs[14];

    // Output ready driver: off, on, or random throttling.
    initial begin
        forever begin
            @(posedge user_clk);
            #1;
            if (ready_mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
            else                 m_axis_tready = (ready_mode == 1);
        end
    end

    // Output monitor: records accepted words and checks hold-while-stalled.
    always @(negedge user_clk) begin
        if (prev_stall && (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} != prev_word)))
            hold_err <= hold_err + 1;
        prev_stall <= m_axis_tvalid && !m_axis_tready;
        prev_word  <= {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tlast, m_axis_tdata});
            obs_total <= obs_total + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        if (gap_en && ($urandom_range(0, 3) == 0)) tick();
        rx_tvalid = 1'b1; rx_tdata = d; rx_tkeep = k; rx_tlast = l;
        tick();
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tkeep = 4'hF;
    endtask

    task automatic send_frame(input logic [15:0] sync, input logic [15:0] len, input logic [3:0] hkeep,
                              input logic hlast, input int kind, input int npay,
                              input logic [31:0] base, input logic [31:0] chk_xor);
        logic [31:0] x;
        x = 32'd0;
        beat({sync, len}, hkeep, hlast);
        if (kind == 0 || kind == 4) begin
            for (int i = 0; i < int'(len); i++) begin
                beat(base + 32'(i), 4'hF, 1'b0);
                x = x ^ (base + 32'(i));
            end
            if (kind == 0) begin
                beat(x ^ chk_xor, 4'hF, 1'b1);
            end else begin
                beat(x, 4'hF, 1'b0);
                beat(32'hDEAD_BEEF, 4'hF, 1'b1);
            end
        end else if (kind == 1 || kind == 2) begin
            for (int i = 0; i < npay; i++) beat(base + 32'(i), 4'hF, (i == npay - 1));
        end
    endtask

    task automatic expect_words(input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), base + 32'(i)});
        exp_total += len;
    endtask

    task automatic check_counts(input string tag, input int lvl);
        check({tag, ".ok"},    64'(frame_ok_cnt), 64'(m_ok));
        check({tag, ".chk"},   64'(chk_err_cnt),  64'(m_chk));
        check({tag, ".fmt"},   64'(fmt_err_cnt),  64'(m_fmt));
        check({tag, ".drop"},  64'(drop_cnt),     64'(m_drop));
        check({tag, ".level"}, 64'(fifo_level),   64'(lvl));
    endtask

    task automatic wait_drain(input string tag);
        int n;
        for (int c = 0; c < 3000 && obs_q.size() < exp_q.size(); c++) tick();
        for (int c = 0; c < 6; c++) tick();
        check({tag, ".nwords"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, ".word"}, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
        check({tag, ".tvalid_idle"}, 64'(m_axis_tvalid), 64'd0);
        check_counts(tag, 0);
    endtask

    initial begin
        vecs[0]  = '{16'hA55A, 16'd3,  4'hF, 1'b0, 0, 0, 32'd1,       32'd0,         1, 0, 0};
        vecs[1]  = '{16'hA55A, 16'd3,  4'hF, 1'b0, 0, 0, 32'd1,       32'd5,         0, 1, 0};
        vecs[2]  = '{16'hA55A, 16'd1,  4'hF, 1'b0, 0, 0, 32'd7,       32'd0,         1, 0, 0};
        vecs[3]  = '{16'hA55A, 16'd4,  4'hF, 1'b0, 1, 2, 32'h10,      32'd0,         0, 0, 1};
        vecs[4]  = '{16'hA55A, 16'd2,  4'hF, 1'b0, 0, 0, 32'h20,      32'd0,         1, 0, 0};
        vecs[5]  = '{16'h1234, 16'd2,  4'hF, 1'b0, 2, 2, 32'h30,      32'd0,         0, 0, 1};
        vecs[6]  = '{16'hA55A, 16'd0,  4'hF, 1'b0, 2, 1, 32'h31,      32'd0,         0, 0, 1};
        vecs[7]  = '{16'hA55A, 16'd17, 4'hF, 1'b0, 2, 3, 32'h32,      32'd0,         0, 0, 1};
        vecs[8]  = '{16'hA55A, 16'd16, 4'hF, 1'b0, 0, 0, 32'h100,     32'd0,         1, 0, 0};
        vecs[9]  = '{16'hA55A, 16'd2,  4'h7, 1'b0, 2, 2, 32'h33,      32'd0,         0, 0, 1};
        vecs[10] = '{16'hA55A, 16'd2,  4'hF, 1'b1, 3, 0, 32'h34,      32'd0,         0, 0, 1};
        vecs[11] = '{16'hA55A, 16'd2,  4'hF, 1'b0, 4, 0, 32'h40,      32'd0,         0, 0, 1};
        vecs[12] = '{16'hA55A, 16'd5,  4'hF, 1'b0, 0, 0, 32'h55,      32'h8000_0000, 0, 1, 0};
        vecs[13] = '{16'hA55A, 16'd5,  4'hF, 1'b0, 0, 0, 32'h1234_5678, 32'd0,       1, 0, 0};

        // Reset state.
        for (int c = 0; c < 3; c++) tick();
        reset = 1'b0;
        tick();
        check("reset.tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset.tdata",  64'(m_axis_tdata),  64'd0);
        check("reset.tlast",  64'(m_axis_tlast),  64'd0);
        check_counts("reset", 0);

        // Table-driven frames, back to back, output always ready.
        ready_mode = 1;
        for (int v = 0; v < 14; v++) begin
            send_frame(vecs[v].sync, vecs[v].len, vecs[v].hkeep, vecs[v].hlast, vecs[v].kind,
                       vecs[v].npay, vecs[v].base, vecs[v].chk_xor);
            m_ok += vecs[v].e_ok; m_chk += vecs[v].e_chk; m_fmt += vecs[v].e_fmt;
            if (vecs[v].e_ok != 0) expect_words(vecs[v].base, int'(vecs[v].len));
            wait_drain($sformatf("vec%0d", v));
        end

        // Commit-to-valid latency into an empty FIFO.
        beat({16'hA55A, 16'd3}, 4'hF, 1'b0);
        beat(32'h200, 4'hF, 1'b0);
        beat(32'h201, 4'hF, 1'b0);
        beat(32'h202, 4'hF, 1'b0);
        beat(32'h200 ^ 32'h201 ^ 32'h202, 4'hF, 1'b1);
        check("lat.cyc0", 64'(m_axis_tvalid), 64'd0);
        tick();
        check("lat.cyc1", 64'(m_axis_tvalid), 64'd0);
        tick();
        check("lat.cyc2", 64'(m_axis_tvalid), 64'd1);
        m_ok++;
        expect_words(32'h200, 3);
        wait_drain("lat");

        // Fill the buffer with output stalled, then a frame that cannot fit.
        ready_mode = 0;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            send_frame(16'hA55A, 16'(MAX_LEN), 4'hF, 1'b0, 0, 0, 32'h1000 * (k + 1), 32'd0);
            m_ok++;
            expect_words(32'h1000 * (k + 1), MAX_LEN);
        end
        send_frame(16'hA55A, 16'(MAX_LEN), 4'hF, 1'b0, 0, 0, 32'h9000, 32'd0);
        m_drop++;
        for (int c = 0; c < 4; c++) tick();
        check("full.tvalid", 64'(m_axis_tvalid), 64'd1);
        check("full.hold",   64'(m_axis_tdata),  64'h1000);
        check_counts("full", DEPTH);
        ready_mode = 1;
        wait_drain("full_drain");
        send_frame(16'hA55A, 16'(MAX_LEN), 4'hF, 1'b0, 0, 0, 32'hA000, 32'd0);
        m_ok++;
        expect_words(32'hA000, MAX_LEN);
        wait_drain("after_full");

        // Link loss while idle (no error) and mid-payload (format error).
        channel_up = 1'b0; tick(); channel_up = 1'b1; tick();
        beat({16'hA55A, 16'd4}, 4'hF, 1'b0);
        beat(32'h301, 4'hF, 1'b0);
        beat(32'h302, 4'hF, 1'b0);
        channel_up = 1'b0; tick(); channel_up = 1'b1;
        m_fmt++;
        send_frame(16'hA55A, 16'd2, 4'hF, 1'b0, 0, 0, 32'h310, 32'd0);
        m_ok++;
        expect_words(32'h310, 2);
        wait_drain("chan_drop");

        // Reset mid-frame.
        beat({16'hA55A, 16'd4}, 4'hF, 1'b0);
        beat(32'h401, 4'hF, 1'b0);
        beat(32'h402, 4'hF, 1'b0);
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        m_ok = 0; m_chk = 0; m_fmt = 0; m_drop = 0;
        tick();
        check_counts("mid_reset", 0);
        send_frame(16'hA55A, 16'd3, 4'hF, 1'b0, 0, 0, 32'h410, 32'd0);
        m_ok++;
        expect_words(32'h410, 3);
        wait_drain("after_reset");

        // Random frames, random gaps, random output throttling.
        ready_mode = 2;
        gap_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len, r;
            logic [31:0] base, cx;
            len  = $urandom_range(1, MAX_LEN);
            r    = $urandom_range(0, 9);
            base = $urandom;
            cx   = $urandom | 32'd1;
            if (r == 0) begin
                send_frame(16'h1234, 16'(len), 4'hF, 1'b0, 0, 0, base, 32'd0);
                m_fmt++;
            end else begin
                for (int c = 0; c < 3000 && (exp_total - obs_total) > (DEPTH - len - 2); c++) tick();
                if (r <= 2) begin
                    send_frame(16'hA55A, 16'(len), 4'hF, 1'b0, 0, 0, base, cx);
                    m_chk++;
                end else begin
                    send_frame(16'hA55A, 16'(len), 4'hF, 1'b0, 0, 0, base, 32'd0);
                    m_ok++;
                    expect_words(base, len);
                end
            end
        end
        gap_en = 1'b0;
        ready_mode = 1;
        wait_drain("random");
        check("hold_stable", 64'(hold_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
